// File: rtl/sig_control_nway_if.sv
// Signal bundle between the N-approach junction controller and its environment.
// The ped_req/walk members exist only when PED_WALK_EN is defined.
interface sig_control_nway_if #(
    parameter int N_CHAN = 4
);
    localparam int SVC_W = (N_CHAN > 1) ? $clog2(N_CHAN) : 1;

    logic [N_CHAN-1:0]   req;
    logic [2*N_CHAN-1:0] lights;
    logic [1:0]          phase;
    logic [SVC_W-1:0]    svc_ch;
`ifdef PED_WALK_EN
    logic                ped_req;
    logic                walk;

    modport master (output req, output ped_req, input lights, input phase, input svc_ch, input walk);
    modport slave  (input req, input ped_req, output lights, output phase, output svc_ch, output walk);
`else
    modport master (output req, input lights, input phase, input svc_ch);
    modport slave  (input req, output lights, output phase, output svc_ch);
`endif
endinterface

// File: rtl/sig_control_nway.sv
// N-approach junction controller: main road (ch0) green by default, side approaches
// served round-robin on demand. Optional pedestrian WALK phase under PED_WALK_EN.
module sig_control_nway #(
   parameter int N_CHAN      = 4,
   parameter int MIN_GREEN   = 8,
   parameter int MAX_GREEN   = 32,
   parameter int Y2R_DELAY   = 3,
   parameter int R2G_DELAY   = 2,
   parameter int WALK_CYCLES = 10,
   parameter int CNT_W       = 8
) (
   input logic               clock,
   input logic               clear,
   sig_control_nway_if.slave bus
);
   localparam int SVC_W = (N_CHAN > 1) ? $clog2(N_CHAN) : 1;
   localparam logic [CNT_W-1:0] MIN_G_M1  = CNT_W'(MIN_GREEN - 1);
   localparam logic [CNT_W-1:0] MAX_G_M1  = CNT_W'(MAX_GREEN - 1);
   localparam logic [CNT_W-1:0] Y2R_M1    = CNT_W'(Y2R_DELAY - 1);
   localparam logic [CNT_W-1:0] R2G_M1    = CNT_W'(R2G_DELAY - 1);
   localparam logic [CNT_W-1:0] WALK_M1   = CNT_W'(WALK_CYCLES - 1);
   localparam logic [CNT_W-1:0] TIMER_SAT = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] TIMER_Z   = {CNT_W{1'b0}};
   localparam logic [2*N_CHAN-1:0] RESET_LIGHTS = {{(2*N_CHAN-2){1'b0}}, 2'd2};

   typedef enum logic [1:0] {
      PH_GREEN  = 2'd0,
      PH_YELLOW = 2'd1,
      PH_ALLRED = 2'd2,
      PH_WALK   = 2'd3
   } phase_t;

   phase_t              phase_r, phase_s;
   logic [SVC_W-1:0]    svc_r, svc_s, nxt_r, nxt_s;
   logic [CNT_W-1:0]    timer_r, timer_s;
   logic [N_CHAN-1:0]   pend_r, pend_s;
   logic [2*N_CHAN-1:0] lights_r;
   logic                green_exit_s;
   logic                ped_active_s;
`ifdef PED_WALK_EN
   logic                ped_pend_r, ped_pend_s;
   logic                walk_done_r, walk_done_s;
   logic                walk_r;
`endif

   // First pending side approach after s (wrapping, skipping ch0 and s); 0 if none.
   function automatic logic [SVC_W-1:0] pick_next(input logic [N_CHAN-1:0] p,
                                                  input logic [SVC_W-1:0]  s);
      logic [SVC_W-1:0] res;
      logic             found;
      int               idx;
      res   = {SVC_W{1'b0}};
      found = 1'b0;
      for (int i = 1; i < N_CHAN; i++) begin
         idx = int'(s) + i;
         idx = (idx >= N_CHAN) ? (idx - N_CHAN) : idx;
         if (!found && (idx != 0) && p[idx]) begin
            res   = SVC_W'(idx);
            found = 1'b1;
         end else begin
            found = found;
         end
      end
      return res;
   endfunction

   function automatic logic [2*N_CHAN-1:0] decode_lights(input phase_t ph,
                                                         input logic [SVC_W-1:0] s);
      logic [2*N_CHAN-1:0] l;
      l = {(2*N_CHAN){1'b0}};
      for (int k = 0; k < N_CHAN; k++) begin
         if (s == SVC_W'(k)) begin
            case (ph)
               PH_GREEN:  l[2*k +: 2] = 2'd2;
               PH_YELLOW: l[2*k +: 2] = 2'd1;
               default:   l[2*k +: 2] = 2'd0;
            endcase
         end else begin
            l[2*k +: 2] = 2'd0;
         end
      end
      return l;
   endfunction

   // Next-state: phase sequencing, phase timer, pending-request bookkeeping.
   always_comb begin
      phase_s      = phase_r;
      svc_s        = svc_r;
      nxt_s        = nxt_r;
      timer_s      = (timer_r == TIMER_SAT) ? timer_r : timer_r + {{(CNT_W-1){1'b0}}, 1'b1};
      pend_s       = pend_r | bus.req;
      green_exit_s = 1'b0;
`ifdef PED_WALK_EN
      ped_active_s = ped_pend_r;
      ped_pend_s   = ped_pend_r | bus.ped_req;
      walk_done_s  = walk_done_r;
`else
      ped_active_s = 1'b0;
`endif
      case (phase_r)
         PH_GREEN: begin
            if (svc_r == {SVC_W{1'b0}}) begin
               green_exit_s = (timer_r >= MIN_G_M1) && ((|pend_r) || ped_active_s);
            end else begin
               green_exit_s = ((timer_r >= MIN_G_M1) && !bus.req[svc_r]) || (timer_r == MAX_G_M1);
            end
            if (green_exit_s) begin
               phase_s = PH_YELLOW;
               timer_s = TIMER_Z;
               nxt_s   = pick_next(pend_r, svc_r);
            end else begin
               phase_s = PH_GREEN;
            end
         end
         PH_YELLOW: begin
            if (timer_r == Y2R_M1) begin
               phase_s = PH_ALLRED;
               timer_s = TIMER_Z;
            end else begin
               phase_s = PH_YELLOW;
            end
         end
         PH_ALLRED: begin
            if (timer_r == R2G_M1) begin
               timer_s = TIMER_Z;
`ifdef PED_WALK_EN
               if (ped_pend_r && !walk_done_r) begin
                  phase_s     = PH_WALK;
                  ped_pend_s  = 1'b0;
                  walk_done_s = 1'b1;
               end else begin
                  phase_s     = PH_GREEN;
                  svc_s       = nxt_r;
                  walk_done_s = 1'b0;
               end
`else
               phase_s = PH_GREEN;
               svc_s   = nxt_r;
`endif
            end else begin
               phase_s = PH_ALLRED;
            end
         end
`ifdef PED_WALK_EN
         PH_WALK: begin
            if (timer_r == WALK_M1) begin
               phase_s = PH_ALLRED;
               timer_s = TIMER_Z;
            end else begin
               phase_s = PH_WALK;
            end
         end
`endif
         default: begin
            phase_s = PH_GREEN;
            svc_s   = {SVC_W{1'b0}};
            timer_s = TIMER_Z;
         end
      endcase
      // Clearing beats setting: the approach that is (or becomes) GREEN never stays pending.
      pend_s[0] = 1'b0;
      for (int k = 1; k < N_CHAN; k++) begin
         if ((phase_s == PH_GREEN) && (svc_s == SVC_W'(k))) begin
            pend_s[k] = 1'b0;
         end else begin
            pend_s[k] = pend_s[k];
         end
      end
   end

   // State, timer, request and output registers.
   always_ff @(posedge clock or posedge clear) begin
      if (clear) begin
         phase_r     <= PH_GREEN;
         svc_r       <= {SVC_W{1'b0}};
         nxt_r       <= {SVC_W{1'b0}};
         timer_r     <= TIMER_Z;
         pend_r      <= {N_CHAN{1'b0}};
         lights_r    <= RESET_LIGHTS;
`ifdef PED_WALK_EN
         ped_pend_r  <= 1'b0;
         walk_done_r <= 1'b0;
         walk_r      <= 1'b0;
`endif
      end else begin
         phase_r     <= phase_s;
         svc_r       <= svc_s;
         nxt_r       <= nxt_s;
         timer_r     <= timer_s;
         pend_r      <= pend_s;
         lights_r    <= decode_lights(phase_s, svc_s);
`ifdef PED_WALK_EN
         ped_pend_r  <= ped_pend_s;
         walk_done_r <= walk_done_s;
         walk_r      <= (phase_s == PH_WALK);
`endif
      end
   end

   assign bus.lights = lights_r;
   assign bus.phase  = phase_r;
   assign bus.svc_ch = svc_r;
`ifdef PED_WALK_EN
   assign bus.walk   = walk_r;
`endif

endmodule

// File: tb/tb_sig_control_nway.sv
// Scoreboard bench for sig_control_nway: expected per-cycle {walk,phase,svc_ch,lights}
// is queued from the intended timing of each scenario and compared on falling edges.
module tb_sig_control_nway;
   localparam int N = 4;

   logic clock = 1'b0;
   logic clear = 1'b1;
   int   n_cmp = 0;
   int   n_err = 0;
   string cur_tag = "reset";
   logic [12:0] sb_q[$];

   always #5 clock = ~clock;

   sig_control_nway_if #(.N_CHAN(N)) bus();

   sig_control_nway #(.N_CHAN(N)) dut (
      .clock (clock),
      .clear (clear),
      .bus   (bus.slave)
   );

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [12:0] obs_now();
      logic w;
`ifdef PED_WALK_EN
      w = bus.walk;
`else
      w = 1'b0;
`endif
      return {w, bus.phase, bus.svc_ch, bus.lights};
   endfunction

   // Expected packed outputs for phase ph with approach ch served.
   function automatic logic [12:0] mk(input int ph, input int ch);
      logic [7:0] l;
      l = 8'h00;
      if (ph == 0) l[2*ch +: 2] = 2'd2;
      else if (ph == 1) l[2*ch +: 2] = 2'd1;
      return {(ph == 3) ? 1'b1 : 1'b0, 2'(ph), 2'(ch), l};
   endfunction

   task automatic push(input int ph, input int ch, input int n);
      for (int i = 0; i < n; i++) sb_q.push_back(mk(ph, ch));
   endtask

   task automatic check_trace();
      logic [12:0] e;
      if (sb_q.size() == 0) begin
         check_val({cur_tag, "_underflow"}, 32'd1, 32'd0);
      end else begin
         e = sb_q.pop_front();
         check_val(cur_tag, {19'd0, obs_now()}, {19'd0, e});
      end
   endtask

   task automatic tick(input logic [N-1:0] r);
      check_trace();
      bus.req = r;
      @(negedge clock);
   endtask

   initial begin
      int total;
      bus.req = 4'b0000;
`ifdef PED_WALK_EN
      bus.ped_req = 1'b0;
`endif
      repeat (2) @(negedge clock);
      check_val("rst_lights", {24'd0, bus.lights}, 32'h02);
      check_val("rst_phase", {30'd0, bus.phase}, 32'd0);
      check_val("rst_svc", {30'd0, bus.svc_ch}, 32'd0);
      check_val("rst_walk", {19'd0, obs_now()}, {19'd0, mk(0, 0)});

      // Single req[2] pulse: ch0 holds MIN_GREEN, ch2 served once, back to ch0.
      cur_tag = "t2_single";
      push(0, 0, 8); push(1, 0, 3); push(2, 0, 2);
      push(0, 2, 8); push(1, 2, 3); push(2, 2, 2); push(0, 0, 10);
      clear = 1'b0;
      total = sb_q.size();
      for (int i = 0; i < total; i++) tick((i == 0) ? 4'b0100 : 4'b0000);

      // Round robin from ch2: ch3, then ch1, then ch0.
      cur_tag = "t3_rr";
      push(0, 0, 2); push(1, 0, 3); push(2, 0, 2);
      push(0, 2, 8); push(1, 2, 3); push(2, 2, 2);
      push(0, 3, 8); push(1, 3, 3); push(2, 3, 2);
      push(0, 1, 8); push(1, 1, 3); push(2, 1, 2); push(0, 0, 10);
      total = sb_q.size();
      for (int i = 0; i < total; i++)
         tick((i == 0) ? 4'b0100 : (i == 7) ? 4'b1010 : 4'b0000);

      // Held req[1]: capped at MAX_GREEN, then ch3, then ch1 again.
      cur_tag = "t4_maxgreen";
      push(0, 0, 2); push(1, 0, 3); push(2, 0, 2);
      push(0, 1, 32); push(1, 1, 3); push(2, 1, 2);
      push(0, 3, 8); push(1, 3, 3); push(2, 3, 2);
      push(0, 1, 8); push(1, 1, 3); push(2, 1, 2); push(0, 0, 10);
      total = sb_q.size();
      for (int i = 0; i < total; i++)
         tick((i == 8) ? 4'b1010 : (i < 44) ? 4'b0010 : 4'b0000);

      // req[2] only on the edge ch2 enters GREEN: clear wins, no re-service.
      cur_tag = "t5_clrwins";
      push(0, 0, 2); push(1, 0, 3); push(2, 0, 2);
      push(0, 2, 8); push(1, 2, 3); push(2, 2, 2); push(0, 0, 10);
      total = sb_q.size();
      for (int i = 0; i < total; i++)
         tick((i == 0 || i == 6) ? 4'b0100 : 4'b0000);

      // Asynchronous clear in the middle of ch2 YELLOW, with req[1] pending.
      cur_tag = "t1_clear";
      push(0, 0, 2); push(1, 0, 3); push(2, 0, 2); push(0, 2, 8); push(1, 2, 3);
      for (int i = 0; i < 17; i++)
         tick((i == 0) ? 4'b0100 : (i == 15) ? 4'b0010 : 4'b0000);
      check_trace();
      #2 clear = 1'b1;
      #1;
      check_val("t1_async_lights", {24'd0, bus.lights}, 32'h02);
      check_val("t1_async_phase", {30'd0, bus.phase}, 32'd0);
      check_val("t1_async_svc", {30'd0, bus.svc_ch}, 32'd0);
      @(negedge clock);
      check_val("t1_queue_empty", sb_q.size(), 32'd0);
      push(0, 0, 12);
      clear = 1'b0;
      for (int i = 0; i < 12; i++) tick(4'b0000);

`ifdef PED_WALK_EN
      // Pedestrian request: WALK between two all-red intervals, then ch0.
      cur_tag = "t6_walk";
      push(0, 0, 2); push(1, 0, 3); push(2, 0, 2);
      push(3, 0, 10); push(2, 0, 2); push(0, 0, 10);
      total = sb_q.size();
      for (int i = 0; i < total; i++) begin
         bus.ped_req = (i == 0) ? 1'b1 : 1'b0;
         tick(4'b0000);
      end
      bus.ped_req = 1'b0;
`endif

      check_val("final_queue_empty", sb_q.size(), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
